stall_ctrl: RTL
===============

Name: stall_ctrl

Overview:
Central pipeline controller. Produces the 6-bit stall vector consumed by every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb) and the flush/new_pc pair for exceptions. Sequences the multi-cycle divider through a start/ready/cancel handshake. Runs a stall watchdog.

Parameters:
EXC_BASE, 32'h0000_0020, exception vector for all non-ERET exception types
STALL_LIMIT, 16, consecutive stall[0] cycles before stall_timeout sets; legal range 1..65535

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
stallreq_from_if  in  1  fetch stage waiting on the bus
stallreq_from_id  in  1  load-use hazard in decode
stallreq_from_ex  in  1  multi-cycle ex op other than divide (madd/msub second cycle)
stallreq_from_mem  in  1  data bus wait
div_req  in  1  divide instruction held in EX; level signal
div_ready  in  1  divider result valid; one-cycle pulse
div_start  out  1  one-cycle pulse launching the divider
div_cancel  out  1  one-cycle pulse aborting the divider
excepttype  in  32  exception code from the mem stage; 0 means none
cp0_epc  in  32  EPC value, used for ERET
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means Stop
flush  out  1  flush all pipeline registers
new_pc  out  32  redirect target when flush=1
stall_timeout  out  1  sticky watchdog flag
perf_stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset: div FSM=IDLE, watchdog count=0, stall_timeout=0, perf_stall_cnt=0. Combinational outputs evaluate with IDLE state: stall=0, flush=0, new_pc=0, div_start=0, div_cancel=0.
- Exceptions (combinational):
  - excepttype!=0 gives flush=1, stall=6'b000000, overriding all stall requests.
  - new_pc=cp0_epc when excepttype==32'h0000_000e (ERET); otherwise EXC_BASE.
  - excepttype==0 gives flush=0, new_pc=0.
- Stall vector (combinational, when flush=0), highest priority first:
  - stallreq_from_mem: 6'b011111
  - stallreq_from_ex or div_stall: 6'b001111
  - stallreq_from_id: 6'b000111
  - stallreq_from_if: 6'b000011
  - otherwise 6'b000000
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE: div_req=1 and flush=0 gives div_start=1 (combinational) and next=BUSY. div_stall=1 in this cycle.
  - BUSY: div_stall=1.
    - div_ready=1 gives next=DONE.
    - div_req=0 or flush=1 gives div_cancel=1 and next=IDLE; this cancel takes precedence over div_ready in the same cycle.
  - DONE: div_stall=0, so EX consumes the result this cycle. Next=IDLE; no new start is possible in DONE.
  - div_ready outside BUSY is ignored.
  - Asynchronous reset mid-BUSY returns to IDLE with no cancel pulse; the divider is reset by the same rst.
- Watchdog:
  - count increments each cycle stall[0]==1, saturating at STALL_LIMIT.
  - count clears when stall[0]==0.
  - stall_timeout sets on the edge where count reaches STALL_LIMIT and stays set until reset.
  - flush cycles count as stall[0]==0.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: perf_stall_cnt increments by 1 on every clk edge where stall[0]==1, wrapping 32'hFFFF_FFFF to 0.
- Undefined: perf_stall_cnt is tied to 32'h0 and the counter logic is absent.

Test Plan:
- stallreq_from_id=1 and stallreq_from_mem=1 together: stall=6'b011111, flush=0. Drop mem: stall=6'b000111.
- div_req held from cycle 0, div_ready at cycle 5:
  - div_start=1 at cycle 0 only
  - stall=6'b001111 for cycles 0-5
  - stall=0 at cycle 6 (DONE)
  - FSM in IDLE at cycle 7
- FSM in BUSY, excepttype=32'h0000_0001 for one cycle: flush=1, stall=0, new_pc=32'h0000_0020, div_cancel=1. Next cycle FSM is IDLE.
- excepttype=32'h0000_000e with cp0_epc=32'h0000_1234: flush=1, new_pc=32'h0000_1234.
- stallreq_from_if held for 16 cycles (STALL_LIMIT=16): stall_timeout rises after the 16th edge. Then release and re-request for 3 cycles: stall_timeout stays 1.
- With CTRL_PERF_CNT_EN, 7 stall cycles after reset gives perf_stall_cnt=7. Assert rst low mid-sequence: all state returns to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/stall_ctrl_if.sv
// Pipeline-control bundle between the stage logic and stall_ctrl.
// master: pipeline side (drives stall requests, divider status, exception info).
// slave : the controller (drives stall vector, flush/redirect, divider handshake).
interface stall_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic        div_req;
  logic        div_ready;
  logic        div_start;
  logic        div_cancel;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] perf_stall_cnt;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output div_req, div_ready, excepttype, cp0_epc,
    input  div_start, div_cancel, stall, flush, new_pc, stall_timeout, perf_stall_cnt
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  div_req, div_ready, excepttype, cp0_epc,
    output div_start, div_cancel, stall, flush, new_pc, stall_timeout, perf_stall_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Central pipeline controller: stall vector, exception flush/redirect,
// divider start/ready/cancel sequencing and a sticky stall watchdog.
// Optional stall-cycle performance counter enabled by `define CTRL_PERF_CNT_EN.
module stall_ctrl #(
  parameter logic [31:0] EXC_BASE    = 32'h0000_0020,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  stall_ctrl_if.slave bus
);

  localparam logic [31:0] ERET_CODE = 32'h0000_000e;
  localparam logic [15:0] LIMIT     = 16'(STALL_LIMIT);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  div_state_e  div_state_q, div_state_d;
  logic        div_stall;
  logic        div_start;
  logic        div_cancel;
  logic        flush;
  logic [31:0] new_pc;
  logic [5:0]  stall_vec;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Exception decode: any nonzero code flushes; ERET returns to EPC.
  always_comb begin
    flush  = |bus.excepttype;
    new_pc = '0;
    if (flush) begin
      new_pc = (bus.excepttype == ERET_CODE) ? bus.cp0_epc : EXC_BASE;
    end
  end

  // Divider handshake next-state and pulses.
  always_comb begin
    div_state_d = div_state_q;
    div_start   = 1'b0;
    div_cancel  = 1'b0;
    div_stall   = 1'b0;
    unique case (div_state_q)
      DIV_IDLE: begin
        if (bus.div_req && !flush) begin
          div_start   = 1'b1;
          div_stall   = 1'b1;
          div_state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        div_stall = 1'b1;
        // Cancel wins over a same-cycle ready: the instruction is gone.
        if (!bus.div_req || flush) begin
          div_cancel  = 1'b1;
          div_state_d = DIV_IDLE;
        end else if (bus.div_ready) begin
          div_state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        div_state_d = DIV_IDLE;
      end
      default: begin
        div_state_d = DIV_IDLE;
      end
    endcase
  end

  // Stall vector, highest-priority request first; flush forces all-go.
  always_comb begin
    stall_vec = '0;
    if (!flush) begin
      if (bus.stallreq_from_mem) begin
        stall_vec = 6'b011111;
      end else if (bus.stallreq_from_ex || div_stall) begin
        stall_vec = 6'b001111;
      end else if (bus.stallreq_from_id) begin
        stall_vec = 6'b000111;
      end else if (bus.stallreq_from_if) begin
        stall_vec = 6'b000011;
      end
    end
  end

  // Watchdog: saturating run-length of PC stalls, sticky timeout flag.
  always_comb begin
    wd_cnt_d = '0;
    if (stall_vec[0]) begin
      wd_cnt_d = (wd_cnt_q == LIMIT) ? wd_cnt_q : wd_cnt_q + 16'd1;
    end
    timeout_d = timeout_q | (wd_cnt_d == LIMIT);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_state_q <= DIV_IDLE;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Free-running stall-cycle counter; wraps naturally.
  always_comb begin
    perf_d = perf_q + {31'd0, stall_vec[0]};
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign bus.perf_stall_cnt = perf_q;
`else
  assign bus.perf_stall_cnt = '0;
`endif

  assign bus.stall         = stall_vec;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.div_start     = div_start;
  assign bus.div_cancel    = div_cancel;
  assign bus.stall_timeout = timeout_q;

endmodule
